// File: rtl/imem_fetch_if.sv
// Fetch-side bus of the instruction memory.
// Carries the request handshake from the PC logic and the response handshake to the decoder.
interface imem_fetch_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 32
);

  logic              req_valid;
  logic [PC_W-1:0]   req_addr;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_inst;
  logic              rsp_fault;
  logic              rsp_ready;

  // Core side: issues fetches and consumes responses
  modport master (
    output req_valid,
    output req_addr,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_inst,
    input  rsp_fault
  );

  // Memory side: accepts fetches and produces responses
  modport slave (
    input  req_valid,
    input  req_addr,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_inst,
    output rsp_fault
  );

endinterface

// File: rtl/imem_fetch.sv
// Word-organised program memory: serial load port in LOAD mode, registered handshaked
// fetch port in RUN mode with misalignment / out-of-range fault reporting.
module imem_fetch #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned PC_W     = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = '0,
  localparam int unsigned IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic [IW:0]       load_count,
  output logic              load_done,
  imem_fetch_if.slave       fetch
);

  // One bit of headroom so DEPTH itself is representable in the range compare
  localparam int unsigned WAW = PC_W - 1;

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_e;

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_inst_q, rsp_inst_d;
  logic              rsp_fault_q, rsp_fault_d;
  logic [IW-1:0]     load_ptr_q, load_ptr_d;
  logic [IW:0]       load_count_d;
  logic              load_done_d;

  logic              mem_we_c;
  logic              ready_c;
  logic              accept_c;
  logic              fault_c;
  logic [WAW-1:0]    word_addr_c;
  logic [IW-1:0]     idx_c;
  logic [DATA_W-1:0] rd_word_c;

  // Fetch address decode and fault detection
  assign word_addr_c = WAW'(fetch.req_addr[PC_W-1:2]);
  assign idx_c       = fetch.req_addr[IW+1:2];
  assign fault_c     = (fetch.req_addr[1:0] != 2'b00) || (word_addr_c >= WAW'(DEPTH));
  assign rd_word_c   = fault_c ? NOP_WORD : mem[idx_c];

  // One-deep output register: accept whenever the slot is empty or being drained
  assign ready_c  = (state_q == RUN) && (!rsp_valid_q || fetch.rsp_ready);
  assign accept_c = fetch.req_valid && ready_c;

  assign fetch.req_ready = ready_c;
  assign fetch.rsp_valid = rsp_valid_q;
  assign fetch.rsp_inst  = rsp_inst_q;
  assign fetch.rsp_fault = rsp_fault_q;

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_inst_d   = rsp_inst_q;
    rsp_fault_d  = rsp_fault_q;
    load_ptr_d   = load_ptr_q;
    load_count_d = load_count;
    load_done_d  = 1'b0;
    mem_we_c     = 1'b0;

    unique case (state_q)
      RUN: begin
        if (load_en) begin
          // Entering LOAD flushes any pending response; a same-edge accept is dropped
          state_d      = LOAD;
          load_ptr_d   = '0;
          load_count_d = '0;
          rsp_valid_d  = 1'b0;
        end else if (accept_c) begin
          rsp_valid_d = 1'b1;
          rsp_inst_d  = rd_word_c;
          rsp_fault_d = fault_c;
        end else if (fetch.rsp_ready) begin
          rsp_valid_d = 1'b0;
        end
      end

      LOAD: begin
        if (!load_en) begin
          // A load_valid coinciding with the exit edge is ignored
          state_d     = RUN;
          load_done_d = 1'b1;
        end else if (load_valid) begin
          mem_we_c   = 1'b1;
          load_ptr_d = (load_ptr_q == IW'(DEPTH - 1)) ? '0 : load_ptr_q + IW'(1);
          if (load_count != (IW+1)'(DEPTH)) begin
            load_count_d = load_count + (IW+1)'(1);
          end
        end
      end

      default: state_d = RUN;
    endcase
  end

  // Control and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      rsp_valid_q <= 1'b0;
      rsp_inst_q  <= '0;
      rsp_fault_q <= 1'b0;
      load_ptr_q  <= '0;
      load_count  <= '0;
      load_done   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_inst_q  <= rsp_inst_d;
      rsp_fault_q <= rsp_fault_d;
      load_ptr_q  <= load_ptr_d;
      load_count  <= load_count_d;
      load_done   <= load_done_d;
    end
  end

  // Program storage; deliberately not reset so contents survive a core reset
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[load_ptr_q] <= load_data;
    end
  end

endmodule

// File: tb/tb_imem_fetch.sv
// Directed bench for imem_fetch: a behavioural memory model feeds a response
// scoreboard queue that is checked with immediate assertions every cycle.
module tb_imem_fetch;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned PC_W   = 32;
  localparam int unsigned IW     = 5;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              load_en = 1'b0;
  logic              load_valid = 1'b0;
  logic [DATA_W-1:0] load_data = '0;
  logic [IW:0]       load_count;
  logic              load_done;

  imem_fetch_if #(.DATA_W(DATA_W), .PC_W(PC_W)) fif ();

  imem_fetch #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .PC_W     (PC_W),
    .NOP_WORD (NOP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_en    (load_en),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_count (load_count),
    .load_done  (load_done),
    .fetch      (fif)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] mem_m [DEPTH];
  logic [32:0] sb_q [$];
  bit          m_load;
  int          m_ptr;
  int          m_cnt;
  bit          exp_done;
  int          n_cmp;
  int          n_bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] expect_rsp(input logic [31:0] addr);
    bit f;
    f = (addr[1:0] != 2'b00) || ((addr >> 2) >= DEPTH);
    return f ? {1'b1, NOP} : {1'b0, mem_m[addr[IW+1:2]]};
  endfunction

  // One clock: check ready before the edge, advance the model, check outputs after
  task automatic step();
    bit          exp_ready;
    bit          acc;
    logic [31:0] a;
    #1;
    exp_ready = !m_load && ((sb_q.size() == 0) || fif.rsp_ready);
    check("req_ready", 32'(fif.req_ready), 32'(exp_ready));
    acc = exp_ready && fif.req_valid;
    a   = fif.req_addr;
    @(posedge clk);
    exp_done = 1'b0;
    if (rst_n) begin
      if (!m_load) begin
        if (load_en) begin
          m_load = 1'b1;
          m_ptr  = 0;
          m_cnt  = 0;
          sb_q.delete();
        end else begin
          if ((sb_q.size() != 0) && fif.rsp_ready) void'(sb_q.pop_front());
          if (acc) sb_q.push_back(expect_rsp(a));
        end
      end else begin
        if (!load_en) begin
          m_load   = 1'b0;
          exp_done = 1'b1;
        end else if (load_valid) begin
          mem_m[m_ptr] = load_data;
          m_ptr = (m_ptr + 1) % DEPTH;
          if (m_cnt < DEPTH) m_cnt++;
        end
      end
    end
    #1;
    check("rsp_valid", 32'(fif.rsp_valid), 32'(sb_q.size() != 0));
    if (sb_q.size() != 0) begin
      check("rsp_inst", fif.rsp_inst, sb_q[0][31:0]);
      check("rsp_fault", 32'(fif.rsp_fault), 32'(sb_q[0][32]));
    end
    check("load_count", 32'(load_count), 32'(m_cnt));
    check("load_done", 32'(load_done), 32'(exp_done));
  endtask

  // Asynchronous reset applied between edges; outputs must clear at once
  task automatic apply_reset();
    rst_n      = 1'b0;
    load_en    = 1'b0;
    load_valid = 1'b0;
    fif.req_valid = 1'b0;
    #1;
    sb_q.delete();
    m_load   = 1'b0;
    m_ptr    = 0;
    m_cnt    = 0;
    exp_done = 1'b0;
    check("rst_rsp_valid", 32'(fif.rsp_valid), 32'd0);
    check("rst_rsp_inst", fif.rsp_inst, 32'd0);
    check("rst_rsp_fault", 32'(fif.rsp_fault), 32'd0);
    check("rst_load_count", 32'(load_count), 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
  endtask

  task automatic fetch_addr(input logic [31:0] addr);
    fif.req_valid = 1'b1;
    fif.req_addr  = addr;
    step();
  endtask

  task automatic load_word(input logic [31:0] w);
    load_valid = 1'b1;
    load_data  = w;
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    fif.req_valid = 1'b0;
    fif.req_addr  = '0;
    fif.rsp_ready = 1'b0;

    // Power-on reset
    #1;
    apply_reset();
    step();
    rst_n = 1'b1;

    // Load the three-instruction program
    load_en = 1'b1;
    step();
    load_word(32'h2008_0005);
    load_word(32'h2009_0007);
    load_word(32'h0109_5020);
    load_valid = 1'b0;
    step();
    load_en = 1'b0;
    step();
    step();

    // Streaming fetch, then faults
    fif.rsp_ready = 1'b1;
    fetch_addr(32'h0);
    fetch_addr(32'h4);
    fetch_addr(32'h8);
    fetch_addr(32'h6);
    fetch_addr(DEPTH * 4);
    fetch_addr(32'h2);
    fetch_addr(32'hFFFF_FFFC);
    fetch_addr(32'h7C);
    fif.req_valid = 1'b0;
    step();

    // Back-pressure: response must hold while the consumer stalls
    fetch_addr(32'h4);
    fif.rsp_ready = 1'b0;
    fif.req_addr  = 32'h8;
    for (int i = 0; i < 3; i++) step();
    fif.rsp_ready = 1'b1;
    step();
    fif.req_valid = 1'b0;
    step();
    step();

    // Overfill: 33 words into 32 entries, with a load_valid on the exit edge
    load_en = 1'b1;
    step();
    for (int i = 0; i < 33; i++) load_word(32'hA000_0000 + 32'(i));
    load_en   = 1'b0;
    load_data = 32'hDEAD_BEEF;
    step();
    load_valid = 1'b0;
    step();
    fetch_addr(32'h0);
    fetch_addr(32'h4);
    fetch_addr(32'h8);
    fif.req_valid = 1'b0;
    step();

    // Reset while a response is stalled
    fif.rsp_ready = 1'b0;
    fetch_addr(32'hC);
    fif.req_valid = 1'b0;
    step();
    apply_reset();
    step();
    rst_n = 1'b1;
    step();

    // Reset in the middle of a load: no done pulse, earlier writes persist
    load_en = 1'b1;
    step();
    load_word(32'hB000_0000);
    load_word(32'hB000_0001);
    apply_reset();
    step();
    rst_n = 1'b1;
    step();
    step();
    fif.rsp_ready = 1'b1;
    fetch_addr(32'h0);
    fetch_addr(32'h4);
    fetch_addr(32'h8);
    fif.req_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_fetch.md
Name: imem_fetch

Overview:
Parametrised successor to the single-cycle instruction memory (IM). Word-organised program memory with a serial load port and a registered, handshaked fetch port. Sits between the PC logic and the decoder; a host or boot loader writes the program in LOAD mode, then the core fetches in RUN mode. Adds misalignment and out-of-range fault reporting, plus back-pressure for stall support.

Parameters:
DATA_W, 32, instruction width in bits
DEPTH, 32, number of words (1..2^16); word index width IW = clog2(DEPTH), minimum 1
PC_W, 32, fetch byte-address width (must be ≥ IW+2)
NOP_WORD, 32'h0000_0000, instruction returned on a fault

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
load_en  in  1  1 = LOAD mode, 0 = RUN mode
load_valid  in  1  load_data valid this cycle (LOAD mode only)
load_data  in  DATA_W  word to write
load_count  out  IW+1  words written since the current load began
load_done  out  1  one-cycle pulse at the end of a load
req_valid  in  1  fetch request
req_addr  in  PC_W  byte address (PC)
req_ready  out  1  fetch accepted when req_valid && req_ready
rsp_valid  out  1  response holds valid data
rsp_inst  out  DATA_W  fetched instruction
rsp_fault  out  1  response is misaligned or out of range
rsp_ready  in  1  consumer accepts the response

Behaviour:
- Async reset (rst_n=0), all outputs take these values at once:
  - state=RUN, rsp_valid=0, rsp_inst=0, rsp_fault=0
  - load_count=0, load_done=0, internal load_ptr=0
- Memory array is not reset; contents persist across reset.
- FSM has two states, RUN and LOAD, sampled at clk:
  - RUN→LOAD when load_en=1. On that edge: load_ptr and load_count clear to 0, and any pending response is flushed (rsp_valid=0).
  - LOAD→RUN when load_en=0. On that edge load_done=1 for exactly one cycle.
- LOAD mode:
  - req_ready=0.
  - Each edge with load_valid=1 writes mem[load_ptr]=load_data.
  - load_ptr wraps DEPTH-1→0.
  - load_count increments and saturates at DEPTH.
  - A load_valid on the same edge as the LOAD→RUN transition is ignored.
- RUN mode handshake:
  - req_ready = (state==RUN) && (!rsp_valid || rsp_ready). This gives a one-deep output register with full throughput.
  - When a request is accepted, the response is registered on that edge; latency is 1 cycle.
  - Word index = req_addr[IW+1:2].
  - Fault when req_addr[1:0]≠0 or req_addr[PC_W-1:2] ≥ DEPTH. On a fault: rsp_inst=NOP_WORD, rsp_fault=1, and memory is not read.
  - No fault: rsp_inst = mem[index], rsp_fault=0.
- Response stability: while rsp_valid && !rsp_ready, rsp_inst and rsp_fault hold stable.
- If rsp_valid && rsp_ready and no new accept, rsp_valid→0 next edge.
- Simultaneous consume + accept: rsp_valid stays 1 and data updates to the new word.
- Reset asserted mid-load: writes already done persist; the load is aborted with no load_done pulse.

Test Plan:
- Reset, then LOAD 3 words (0x20080005, 0x20090007, 0x01095020) → load_count=3. Drop load_en → load_done high one cycle.
- RUN, rsp_ready=1, req_addr 0,4,8 on consecutive cycles → req_ready=1 throughout. rsp_inst=0x20080005, 0x20090007, 0x01095020 one cycle after each request, rsp_fault=0.
- req_addr=0x6 → rsp_inst=NOP_WORD, rsp_fault=1. req_addr=DEPTH*4 (0x80 at default) → rsp_fault=1.
- Back-pressure: rsp_ready=0 for 3 cycles after fetching addr 4 → rsp_inst holds 0x20090007, req_ready=0. Raise rsp_ready with a new request to 8 → next cycle 0x01095020, no bubble.
- Load 33 words with DEPTH=32 → word 32 overwrites addr 0, load_count saturates at 32, fetch of 0 returns word 32.
- Assert rst_n=0 mid-response and mid-load → rsp_valid=0 immediately, no load_done pulse, earlier-written words still read back after reset.
